// File: rtl/pipeline_stall_ctrl_if.sv
// Hazard/stall handshake between the pipeline datapath and the stall controller.
// The datapath drives the requests (master); the controller answers with enables and statistics (slave).
interface pipeline_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             hazard_req;
    logic             branch_taken;
    logic             dmem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             mem_freeze;
    logic             stall_active;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output hazard_req, branch_taken, dmem_busy,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_freeze,
        input  stall_active, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  hazard_req, branch_taken, dmem_busy,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, mem_freeze,
        output stall_active, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Load-use / branch / memory-wait stall controller for a 5-stage MIPS pipeline.
// Control outputs are combinational from state and requests; state and statistics are registered.
module pipeline_stall_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int MAX_MEM_WAIT      = 15,
    parameter int CNT_W             = 32
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_stall_ctrl_if.slave bus
);
    localparam int LCNT_W = (LOAD_STALL_CYCLES > 1) ? $clog2(LOAD_STALL_CYCLES) : 1;
    localparam int WCNT_W = $clog2(MAX_MEM_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_MWAIT  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    state_t             resume_reg, resume_next;
    state_t             eff_state;
    logic [LCNT_W-1:0]  lcnt_reg, lcnt_next;
    logic [WCNT_W-1:0]  wcnt_reg, wcnt_next;
    logic               timeout_reg, timeout_next;
    logic [CNT_W-1:0]   stall_cnt_reg;
    logic [CNT_W-1:0]   flush_cnt_reg;

    logic pc_write_c, if_id_write_c, if_id_flush_c, id_ex_bubble_c, mem_freeze_c;

    always_comb begin
        state_next     = state_reg;
        resume_next    = resume_reg;
        lcnt_next      = lcnt_reg;
        wcnt_next      = wcnt_reg;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        mem_freeze_c   = 1'b0;

        // Leaving MWAIT behaves as if the saved state were current this very cycle.
        eff_state = (state_reg == ST_MWAIT) ? resume_reg : state_reg;

        if (bus.dmem_busy) begin
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            mem_freeze_c  = 1'b1;
            if (state_reg != ST_MWAIT) begin
                resume_next = state_reg;
                state_next  = ST_MWAIT;
                wcnt_next   = WCNT_W'(1);
            end else if (wcnt_reg != WCNT_W'(MAX_MEM_WAIT)) begin
                wcnt_next = wcnt_reg + WCNT_W'(1);
            end
        end else if (bus.branch_taken) begin
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            state_next     = ST_RUN;
        end else if (eff_state == ST_LSTALL) begin
            pc_write_c     = 1'b0;
            if_id_write_c  = 1'b0;
            id_ex_bubble_c = 1'b1;
            if (lcnt_reg == LCNT_W'(1)) begin
                state_next = ST_RUN;
            end else begin
                state_next = ST_LSTALL;
                lcnt_next  = lcnt_reg - LCNT_W'(1);
            end
        end else begin
            state_next = ST_RUN;
            if (bus.hazard_req) begin
                pc_write_c     = 1'b0;
                if_id_write_c  = 1'b0;
                id_ex_bubble_c = 1'b1;
                if (LOAD_STALL_CYCLES > 1) begin
                    state_next = ST_LSTALL;
                    lcnt_next  = LCNT_W'(LOAD_STALL_CYCLES - 1);
                end
            end
        end

        timeout_next = timeout_reg | (bus.dmem_busy && (wcnt_next == WCNT_W'(MAX_MEM_WAIT)));

        if (rst) begin
            pc_write_c     = 1'b1;
            if_id_write_c  = 1'b1;
            if_id_flush_c  = 1'b0;
            id_ex_bubble_c = 1'b0;
            mem_freeze_c   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_RUN;
            resume_reg    <= ST_RUN;
            lcnt_reg      <= '0;
            wcnt_reg      <= '0;
            timeout_reg   <= 1'b0;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            resume_reg  <= resume_next;
            lcnt_reg    <= lcnt_next;
            wcnt_reg    <= wcnt_next;
            timeout_reg <= timeout_next;
            if (!pc_write_c && (stall_cnt_reg != '1))
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (if_id_flush_c && (flush_cnt_reg != '1))
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.pc_write     = pc_write_c;
    assign bus.if_id_write  = if_id_write_c;
    assign bus.if_id_flush  = if_id_flush_c;
    assign bus.id_ex_bubble = id_ex_bubble_c;
    assign bus.mem_freeze   = mem_freeze_c;
    assign bus.stall_active = ~pc_write_c;
    assign bus.mem_timeout  = timeout_reg;
    assign bus.stall_cycles = stall_cnt_reg;
    assign bus.flush_count  = flush_cnt_reg;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Two controller instances (1-bubble/32-bit counters and 3-bubble/4-bit counters) share one stimulus
// stream and are compared every cycle against a pending-bubble / busy-run reference model.
module tb_pipeline_stall_ctrl;
    localparam int MAXW = 15;
    localparam int LA   = 1;
    localparam int LB   = 3;
    localparam int CW_A = 32;
    localparam int CW_B = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hz = 1'b0, br = 1'b0, busy = 1'b0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl_if #(.CNT_W(CW_A)) bus_a ();
    pipeline_stall_ctrl_if #(.CNT_W(CW_B)) bus_b ();

    assign bus_a.hazard_req   = hz;
    assign bus_a.branch_taken = br;
    assign bus_a.dmem_busy    = busy;
    assign bus_b.hazard_req   = hz;
    assign bus_b.branch_taken = br;
    assign bus_b.dmem_busy    = busy;

    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(LA), .MAX_MEM_WAIT(MAXW), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    pipeline_stall_ctrl #(.LOAD_STALL_CYCLES(LB), .MAX_MEM_WAIT(MAXW), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: bubbles still owed, length of the current busy run, and plain counters.
    int          m_pend  [2];
    int          m_brun  [2];
    bit          m_tmo   [2];
    longint      m_stall [2];
    longint      m_flush [2];
    int          m_l     [2];
    longint      m_cap   [2];

    logic        s_pc [2], s_ifw [2], s_fl [2], s_bub [2], s_frz [2], s_sa [2], s_tmo [2];
    logic [63:0] s_stall [2], s_flush [2];

    typedef struct {
        bit h, b, m;
        bit pc, fl, bub, frz;
    } vec_t;
    vec_t tbl [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_step(input int d, input bit h, input bit b, input bit m, input bit r,
                              output bit pc, output bit fl, output bit bub, output bit frz);
        pc = 1'b1; fl = 1'b0; bub = 1'b0; frz = 1'b0;
        if (r) begin
            m_pend[d] = 0; m_brun[d] = 0; m_tmo[d] = 1'b0; m_stall[d] = 0; m_flush[d] = 0;
        end else begin
            if (m) begin
                pc = 1'b0; frz = 1'b1;
                m_brun[d]++;
                if (m_brun[d] >= MAXW) m_tmo[d] = 1'b1;
            end else begin
                m_brun[d] = 0;
                if (b) begin
                    fl = 1'b1; bub = 1'b1; m_pend[d] = 0;
                end else if (m_pend[d] > 0) begin
                    pc = 1'b0; bub = 1'b1; m_pend[d]--;
                end else if (h) begin
                    pc = 1'b0; bub = 1'b1; m_pend[d] = m_l[d] - 1;
                end
            end
            if (!pc && m_stall[d] < m_cap[d]) m_stall[d]++;
            if (fl && m_flush[d] < m_cap[d]) m_flush[d]++;
        end
    endtask

    task automatic sample_comb();
        s_pc[0] = bus_a.pc_write;     s_pc[1] = bus_b.pc_write;
        s_ifw[0] = bus_a.if_id_write; s_ifw[1] = bus_b.if_id_write;
        s_fl[0] = bus_a.if_id_flush;  s_fl[1] = bus_b.if_id_flush;
        s_bub[0] = bus_a.id_ex_bubble; s_bub[1] = bus_b.id_ex_bubble;
        s_frz[0] = bus_a.mem_freeze;  s_frz[1] = bus_b.mem_freeze;
        s_sa[0] = bus_a.stall_active; s_sa[1] = bus_b.stall_active;
    endtask

    task automatic sample_regs();
        s_tmo[0] = bus_a.mem_timeout;  s_tmo[1] = bus_b.mem_timeout;
        s_stall[0] = 64'(bus_a.stall_cycles); s_stall[1] = 64'(bus_b.stall_cycles);
        s_flush[0] = 64'(bus_a.flush_count);  s_flush[1] = 64'(bus_b.flush_count);
    endtask

    // One clock of stimulus: drive at negedge, check control outputs mid-cycle, check state after the edge.
    task automatic cycle(input bit h, input bit b, input bit m, input bit r);
        bit e_pc, e_fl, e_bub, e_frz;
        string p;
        @(negedge clk);
        hz = h; br = b; busy = m; rst = r;
        #2;
        sample_comb();
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "a." : "b.";
            model_step(d, h, b, m, r, e_pc, e_fl, e_bub, e_frz);
            check({p, "pc_write"}, s_pc[d], e_pc);
            check({p, "if_id_write"}, s_ifw[d], e_pc);
            check({p, "if_id_flush"}, s_fl[d], e_fl);
            check({p, "id_ex_bubble"}, s_bub[d], e_bub);
            check({p, "mem_freeze"}, s_frz[d], e_frz);
            check({p, "stall_active"}, s_sa[d], !e_pc);
        end
        @(posedge clk);
        #1;
        sample_regs();
        for (int d = 0; d < 2; d++) begin
            p = (d == 0) ? "a." : "b.";
            check({p, "stall_cycles"}, s_stall[d], 64'(m_stall[d]));
            check({p, "flush_count"}, s_flush[d], 64'(m_flush[d]));
            check({p, "mem_timeout"}, s_tmo[d], m_tmo[d]);
        end
    endtask

    task automatic do_reset();
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
    endtask

    initial begin
        logic [3:0] pat;
        int burst;
        bit h, b, m, r;

        m_l[0] = LA;  m_cap[0] = (64'd1 << CW_A) - 1;
        m_l[1] = LB;  m_cap[1] = (64'd1 << CW_B) - 1;
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 0; m_brun[d] = 0; m_tmo[d] = 1'b0; m_stall[d] = 0; m_flush[d] = 0;
        end

        tbl[0] = '{h:0, b:0, m:0, pc:1, fl:0, bub:0, frz:0};
        tbl[1] = '{h:1, b:0, m:0, pc:0, fl:0, bub:1, frz:0};
        tbl[2] = '{h:0, b:0, m:0, pc:1, fl:0, bub:0, frz:0};
        tbl[3] = '{h:1, b:1, m:0, pc:1, fl:1, bub:1, frz:0};
        tbl[4] = '{h:0, b:0, m:1, pc:0, fl:0, bub:0, frz:1};
        tbl[5] = '{h:0, b:1, m:1, pc:0, fl:0, bub:0, frz:1};
        tbl[6] = '{h:0, b:1, m:0, pc:1, fl:1, bub:1, frz:0};
        tbl[7] = '{h:1, b:0, m:1, pc:0, fl:0, bub:0, frz:1};
        tbl[8] = '{h:1, b:0, m:0, pc:0, fl:0, bub:1, frz:0};
        tbl[9] = '{h:0, b:0, m:0, pc:1, fl:0, bub:0, frz:0};

        // Reset state
        do_reset();
        check("rst.pc_write", s_pc[0], 1'b1);
        check("rst.stall_cycles", s_stall[0], 64'd0);
        check("rst.mem_timeout", s_tmo[1], 1'b0);

        // Table vectors against the single-bubble instance
        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].h, tbl[i].b, tbl[i].m, 1'b0);
            check($sformatf("tbl%0d.pc_write", i), s_pc[0], tbl[i].pc);
            check($sformatf("tbl%0d.if_id_flush", i), s_fl[0], tbl[i].fl);
            check($sformatf("tbl%0d.id_ex_bubble", i), s_bub[0], tbl[i].bub);
            check($sformatf("tbl%0d.mem_freeze", i), s_frz[0], tbl[i].frz);
        end
        check("tbl.stall_cycles", s_stall[0], 64'd5);
        check("tbl.flush_count", s_flush[0], 64'd2);

        // Three-bubble load-use stall
        do_reset();
        cycle(1, 0, 0, 0); pat[0] = s_bub[1];
        for (int i = 1; i < 4; i++) begin
            cycle(0, 0, 0, 0); pat[i] = s_bub[1];
        end
        check("lstall3.bubbles", 64'(pat), 64'(4'b0111));
        check("lstall3.stall_cycles", s_stall[1], 64'd3);

        // Branch beats a simultaneous hazard
        do_reset();
        cycle(1, 1, 0, 0);
        check("br_hz.if_id_flush", s_fl[0], 1'b1);
        check("br_hz.pc_write", s_pc[0], 1'b1);
        check("br_hz.flush_count", s_flush[0], 64'd1);
        check("br_hz.stall_cycles", s_stall[0], 64'd0);

        // Memory wait in the middle of a load stall; remaining bubbles resume afterwards
        do_reset();
        cycle(1, 0, 0, 0);
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 1, 0); pat[i] = s_frz[1];
        end
        check("mwait.freeze", 64'(pat), 64'(4'b1111));
        pat = '0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0); pat[i] = s_bub[1];
        end
        check("mwait.resume_bubbles", 64'(pat), 64'(4'b0011));
        check("mwait.stall_cycles", s_stall[1], 64'd7);

        // Memory timeout is sticky until reset
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            cycle(0, 0, 1, 0);
            if (i == 14) check("tmo.before", s_tmo[0], 1'b0);
        end
        check("tmo.at15", s_tmo[0], 1'b1);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        check("tmo.sticky", s_tmo[0], 1'b1);
        cycle(0, 0, 0, 1);
        check("tmo.cleared", s_tmo[0], 1'b0);

        // Flush-counter saturation, then reset in the middle of a load stall
        do_reset();
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
        check("sat.flush_b", s_flush[1], 64'd15);
        check("sat.flush_a", s_flush[0], 64'd20);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 1);
        check("midrst.pc_write", s_pc[1], 1'b1);
        check("midrst.id_ex_bubble", s_bub[1], 1'b0);
        check("midrst.flush_count", s_flush[1], 64'd0);
        check("midrst.stall_cycles", s_stall[1], 64'd0);
        cycle(0, 0, 0, 0);
        check("midrst.no_bubble", s_bub[1], 1'b0);

        // Randomized traffic with bursty memory waits
        burst = 0;
        for (int i = 0; i < 500; i++) begin
            h = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 199) == 0);
            if (burst == 0 && $urandom_range(0, 9) == 0) burst = $urandom_range(1, 18);
            m = (burst > 0);
            if (burst > 0) burst--;
            cycle(h, b, m, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
